alu_multicycle: RTL

//  Parametrised successor to the single-cycle datapath ALU. Takes rs/rt plus a 3-bit op,

---
 rtl/alu_multicycle_if.sv | 32 +++
 rtl/alu_multicycle.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle_if
// Purpose  : Operand/result handshake bundle between register read and the ALU.
// Revision : 1.0  initial release
// ============================================================================
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;

   modport slave (
      input  in_valid, op, rs, rt, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow
   );

   modport master (
      output in_valid, op, rs, rt, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow
   );
endinterface
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Registered ALU with valid/ready handshake; MUL is iterative shift-add.
// Revision : 1.0  initial release
// ============================================================================
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  wire logic       clock,
   input  wire logic       reset,
   alu_multicycle_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_ZERO = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_ovf;
   logic [2*WIDTH-1:0] acc_step;

   always_comb begin
      add_full  = {1'b0, bus.rs} + {1'b0, bus.rt};
      sub_full  = {1'b0, bus.rs} - {1'b0, bus.rt};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res   = add_full[WIDTH-1:0];
            alu_carry = add_full[WIDTH];
            alu_ovf   = (bus.rs[WIDTH-1] == bus.rt[WIDTH-1]) &&
                        (add_full[WIDTH-1] != bus.rs[WIDTH-1]);
         end
         OP_SUB: begin
            // bit WIDTH of the zero-extended difference is the unsigned borrow
            alu_res   = sub_full[WIDTH-1:0];
            alu_carry = sub_full[WIDTH];
            alu_ovf   = (bus.rs[WIDTH-1] != bus.rt[WIDTH-1]) &&
                        (sub_full[WIDTH-1] != bus.rs[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.rs & bus.rt;
         OP_OR:   alu_res = bus.rs | bus.rt;
         OP_XOR:  alu_res = bus.rs ^ bus.rt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.rs) < $signed(bus.rt))};
         default: alu_res = '0;
      endcase
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (bus.op == OP_MUL) begin
                  state_d  = S_BUSY;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, bus.rs};
                  mplier_d = bus.rt;
               end else begin
                  state_d    = S_DONE;
                  result_d   = alu_res;
                  zero_d     = (alu_res == '0);
                  carry_d    = alu_carry;
                  overflow_d = alu_ovf;
               end
            end
         end
         S_BUSY: begin
            // fixed WIDTH iterations regardless of operand values
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d    = S_DONE;
               result_d   = acc_step[WIDTH-1:0];
               zero_d     = (acc_step[WIDTH-1:0] == '0);
               carry_d    = 1'b0;
               overflow_d = |acc_step[2*WIDTH-1:WIDTH];
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire
